// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, FSM state and counter width helper for the PE datapath
package pe_pkg;
  localparam int PRECISION = 16;
  localparam int OUTPUT_PRECISION = 2 * PRECISION;
  localparam int ACC_PRECISION = 40;
  typedef enum logic {IDLE, ACK} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/pe_dot_collector_if.sv
// pe_dot_collector_if: PE product handshake plus downstream result valid/ready
interface pe_dot_collector_if #(
  parameter int OUTPUT_PRECISION = pe_pkg::OUTPUT_PRECISION,
  parameter int ACC_PRECISION = pe_pkg::ACC_PRECISION
);
  logic mult_issued, pe_ready, pe_ack, dot_valid, dot_ready;
  logic [OUTPUT_PRECISION-1:0] pe_s_out;
  logic [ACC_PRECISION-1:0] dot_out;
  modport master(output mult_issued, pe_ready, pe_s_out, dot_ready, input pe_ack, dot_out, dot_valid);
  modport slave(input mult_issued, pe_ready, pe_s_out, dot_ready, output pe_ack, dot_out, dot_valid);
endinterface

// File: rtl/pe_dot_collector_result_fifo.sv
// result_fifo: show-ahead synchronous FIFO with occupancy count
module result_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign valid = count != '0;
  assign dout = valid ? mem[rd_ptr] : '0;
  assign do_pop = pop && valid;
  assign do_push = push && (count < FULL || do_pop);
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/pe_dot_collector.sv
// pe_dot_collector: accumulates PE products into dot products and queues the results
module pe_dot_collector import pe_pkg::*; #(
  parameter int OUTPUT_PRECISION = pe_pkg::OUTPUT_PRECISION,
  parameter int ACC_PRECISION = pe_pkg::ACC_PRECISION,
  parameter int VECTOR_LEN = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic CLK,
  input  logic reset,
  pe_dot_collector_if.slave bus,
  output logic [cnt_w(VECTOR_LEN)-1:0] elem_cnt,
  output logic [cnt_w(FIFO_DEPTH)-1:0] fifo_count,
  output logic overrun
);
  localparam int EW = cnt_w(VECTOR_LEN);
  localparam int FW = cnt_w(FIFO_DEPTH);
  localparam logic [EW-1:0] LAST = EW'(VECTOR_LEN - 1);
  localparam logic [FW-1:0] FULL = FW'(FIFO_DEPTH);
  state_t state;
  logic [ACC_PRECISION-1:0] acc, sum;
  logic pending, space, last, capture;
  assign sum = acc + ACC_PRECISION'(bus.pe_s_out);
  assign last = elem_cnt == LAST;
  // a pop this cycle frees the slot the final element is about to fill
  assign space = fifo_count < FULL || (bus.dot_valid && bus.dot_ready);
  assign capture = state == IDLE && pending && bus.pe_ready && (space || !last);
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      elem_cnt <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      bus.pe_ack <= 1'b0;
    end else begin
      state <= capture ? ACK : IDLE;
      bus.pe_ack <= capture;
      pending <= bus.mult_issued || (pending && !capture);
      if (bus.mult_issued && pending && !capture) overrun <= 1'b1;
      if (capture) begin
        acc <= last ? '0 : sum;
        elem_cnt <= last ? '0 : elem_cnt + 1'b1;
      end
    end
  end
  result_fifo #(.WIDTH(ACC_PRECISION), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK),
    .reset(reset),
    .push(capture && last),
    .pop(bus.dot_ready),
    .din(sum),
    .dout(bus.dot_out),
    .valid(bus.dot_valid),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_pe_dot_collector.sv
// tb_pe_dot_collector: directed scoreboard bench for pe_dot_collector
module tb_pe_dot_collector;
  logic CLK = 1'b0;
  logic reset;
  logic [2:0] elem_cnt;
  logic [1:0] fifo_count;
  logic overrun;
  logic [32:0] sb [$];
  logic [32:0] m_acc;
  int m_cnt;
  int checks = 0;
  int errors = 0;
  logic dv;
  logic [32:0] dval;

  pe_dot_collector_if #(.OUTPUT_PRECISION(32), .ACC_PRECISION(33)) bus();

  pe_dot_collector #(.OUTPUT_PRECISION(32), .ACC_PRECISION(33), .VECTOR_LEN(4), .FIFO_DEPTH(2)) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus),
    .elem_cnt(elem_cnt),
    .fifo_count(fifo_count),
    .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model(input logic [31:0] v);
    m_acc = m_acc + {1'b0, v};
    m_cnt++;
    if (m_cnt == 4) begin
      sb.push_back(m_acc);
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_acc = '0;
    m_cnt = 0;
    sb.delete();
  endtask

  // issues one product and waits for its acknowledge; reports the head result seen in the ACK cycle
  task automatic issue(input logic [31:0] v, output logic head_valid, output logic [32:0] head);
    logic got;
    got = 1'b0;
    bus.mult_issued = 1'b1;
    step();
    bus.mult_issued = 1'b0;
    bus.pe_s_out = v;
    bus.pe_ready = 1'b1;
    model(v);
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = bus.pe_ack;
    end
    head_valid = bus.dot_valid;
    head = bus.dot_out;
    bus.pe_ready = 1'b0;
    check("ack_seen", {63'b0, got}, 64'd1);
    step();
    check("ack_width", {63'b0, bus.pe_ack}, 64'd0);
  endtask

  always @(negedge CLK) begin
    if (!reset && bus.dot_valid && bus.dot_ready) begin
      if (sb.size() == 0) check("sb_unexpected", 64'd1, 64'd0);
      else check("sb_dot_out", {31'b0, bus.dot_out}, {31'b0, sb.pop_front()});
    end
  end

  initial begin
    bus.mult_issued = 1'b0;
    bus.pe_ready = 1'b0;
    bus.pe_s_out = '0;
    bus.dot_ready = 1'b0;
    reset = 1'b1;
    step();
    do_reset();
    check("rst_ack", {63'b0, bus.pe_ack}, 64'd0);
    check("rst_valid", {63'b0, bus.dot_valid}, 64'd0);
    check("rst_dot_out", {31'b0, bus.dot_out}, 64'd0);
    check("rst_elem_cnt", {61'b0, elem_cnt}, 64'd0);
    check("rst_fifo_count", {62'b0, fifo_count}, 64'd0);
    check("rst_overrun", {63'b0, overrun}, 64'd0);

    bus.pe_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("artefact_ack", {63'b0, bus.pe_ack}, 64'd0);
    end
    check("artefact_elem_cnt", {61'b0, elem_cnt}, 64'd0);
    bus.pe_ready = 1'b0;

    bus.dot_ready = 1'b1;
    issue(32'd3, dv, dval);
    check("basic_elem_cnt", {61'b0, elem_cnt}, 64'd1);
    issue(32'd5, dv, dval);
    issue(32'd7, dv, dval);
    issue(32'd9, dv, dval);
    check("basic_valid", {63'b0, dv}, 64'd1);
    check("basic_sum", {31'b0, dval}, 64'd24);
    check("basic_valid_gone", {63'b0, bus.dot_valid}, 64'd0);
    check("basic_elem_cnt_clr", {61'b0, elem_cnt}, 64'd0);

    for (int i = 0; i < 4; i++) issue(32'hFFFF_FFFF, dv, dval);
    check("wrap_sum", {31'b0, dval}, 64'h1_FFFF_FFFC);

    bus.dot_ready = 1'b0;
    issue(32'd1, dv, dval);
    issue(32'd2, dv, dval);
    issue(32'd3, dv, dval);
    issue(32'd4, dv, dval);
    for (int i = 0; i < 4; i++) issue(32'd10 * (i + 1), dv, dval);
    check("bp_full", {62'b0, fifo_count}, 64'd2);
    for (int i = 0; i < 3; i++) issue(32'd5, dv, dval);
    bus.mult_issued = 1'b1;
    step();
    bus.mult_issued = 1'b0;
    bus.pe_s_out = 32'd5;
    bus.pe_ready = 1'b1;
    model(32'd5);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_withheld", {63'b0, bus.pe_ack}, 64'd0);
    end
    check("bp_elem_cnt", {61'b0, elem_cnt}, 64'd3);
    bus.dot_ready = 1'b1;
    step();
    bus.dot_ready = 1'b0;
    bus.pe_ready = 1'b0;
    check("bp_release_ack", {63'b0, bus.pe_ack}, 64'd1);
    check("bp_count_kept", {62'b0, fifo_count}, 64'd2);
    check("bp_elem_cnt_clr", {61'b0, elem_cnt}, 64'd0);
    bus.dot_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("bp_drained", {62'b0, fifo_count}, 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    bus.mult_issued = 1'b1;
    step();
    bus.mult_issued = 1'b0;
    step();
    check("ovr_clear", {63'b0, overrun}, 64'd0);
    bus.mult_issued = 1'b1;
    step();
    bus.mult_issued = 1'b0;
    check("ovr_set", {63'b0, overrun}, 64'd1);
    for (int i = 0; i < 5; i++) step();
    check("ovr_sticky", {63'b0, overrun}, 64'd1);
    do_reset();
    check("ovr_reset", {63'b0, overrun}, 64'd0);

    issue(32'd7, dv, dval);
    issue(32'd8, dv, dval);
    check("mid_elem_cnt", {61'b0, elem_cnt}, 64'd2);
    do_reset();
    check("mid_rst_elem_cnt", {61'b0, elem_cnt}, 64'd0);
    check("mid_rst_valid", {63'b0, bus.dot_valid}, 64'd0);
    check("mid_rst_fifo", {62'b0, fifo_count}, 64'd0);
    check("mid_rst_ack", {63'b0, bus.pe_ack}, 64'd0);
    for (int i = 0; i < 4; i++) issue(32'd1, dv, dval);
    check("mid_sum", {31'b0, dval}, 64'd4);
    for (int i = 0; i < 3; i++) step();
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_dot_collector.md
# pe_dot_collector

Downstream consumer of `processing_element`. Captures each product the PE presents on its `pe_ready`/`pe_ack` handshake and accumulates `VECTOR_LEN` products into one dot-product result. Completed results are buffered in a small FIFO and presented to the next stage on a valid/ready interface. The block supplies the accumulation the PE itself does not perform and applies backpressure to the PE when the output FIFO is full.

## Interface
- `OUTPUT_PRECISION`, 32: width of PE product (`pe_s_out`).
- `ACC_PRECISION`, 40: accumulator and result width; must be ≥ `OUTPUT_PRECISION`.
- `VECTOR_LEN`, 8: products per dot product; ≥ 1.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥ 2.

- `CLK`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mult_issued`  in  1  pulse; same signal that drives the PE's `start_multiply`.
- `pe_ready`  in  1  PE has a product on `pe_s_out`.
- `pe_s_out`  in  OUTPUT_PRECISION  PE product, unsigned.
- `pe_ack`  out  1  one-cycle acknowledge to the PE.
- `dot_out`  out  ACC_PRECISION  FIFO head result.
- `dot_valid`  out  1  FIFO non-empty.
- `dot_ready`  in  1  downstream accepts `dot_out`.
- `elem_cnt`  out  clog2(VECTOR_LEN)+1  products accumulated in the current vector.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  entries held.
- `overrun`  out  1  sticky error flag.

## Operation
- Reset values: all outputs are 0, accumulator is 0, `pending` is 0, FSM is IDLE. FIFO pointers are cleared. Reset has priority over every other event, including mid-vector and during ACK. Partial sums are discarded.
- `pending` flag: set by `mult_issued`. Cleared on capture. It gates capture, so the PE's reset-time `pe_ready`=1 with a zero product is never consumed.
- If `mult_issued`=1 while `pending`=1 and no capture happens in the same cycle, `overrun` is set. It stays set until `reset`.
- FSM IDLE:
  - Capture condition: `pending` && `pe_ready` && space.
  - `space` is `fifo_count < FIFO_DEPTH`, or `dot_valid && dot_ready` (a pop frees an entry). It is only required for the last element. Non-last captures always proceed.
  - On capture: `acc <= acc + zext(pe_s_out)`, `elem_cnt` increments, `pe_ack <= 1`, next state is ACK.
  - Last element (`elem_cnt == VECTOR_LEN-1`): the full sum is pushed to the FIFO, then `acc` and `elem_cnt` are cleared to 0.
  - If capture is blocked by a full FIFO, the block stays in IDLE and `pe_ack` stays low. The PE holds its product.
- FSM ACK: `pe_ack` is 1 for exactly this cycle. `pe_ready` is ignored here because the PE clears it at the end of this cycle. The next state is always IDLE.
- Arithmetic: unsigned, modulo 2^ACC_PRECISION. Wraps silently with no saturation.
- FIFO: a push and a pop in the same cycle are both honoured, and `fifo_count` is unchanged. A pop when empty is ignored. Order is first in, first out.

## Timing
- Capture edge at the end of cycle t: `pe_ack`=1 during t+1. If t was the last element, `dot_valid`=1 and `dot_out`=sum in t+1, provided the FIFO was empty.
- Minimum spacing between captures is 2 cycles (IDLE→ACK→IDLE).
- `dot_out`/`dot_valid` are registered from FIFO state, with no combinational path from `dot_ready`.
- The PE-side `space` check uses `dot_ready`. This is the only input-to-state path through the FIFO.

## Structure
- Shared package `pe_pkg`:
  - `PRECISION`, `OUTPUT_PRECISION`, `ACC_PRECISION` defaults.
  - FSM state enum `{IDLE, ACK}`.
  - Width helper constants for counters.
- Sub-module `result_fifo`: synchronous FIFO with show-ahead head and a count output, parameterised by width and depth. Instantiated once.
- The top level holds the FSM, the accumulator, `pending`/`overrun` and `elem_cnt`.

## Test plan
- **Basic vector:** VECTOR_LEN=4, `dot_ready`=1, products 3,5,7,9 each preceded by `mult_issued` → one `pe_ack` pulse per product, each 1 cycle wide. `dot_out`=24 with `dot_valid` for one cycle, after which `elem_cnt`=0.
- **PE reset artefact:** `pe_ready`=1 and `pe_s_out`=0 with `pending`=0 for 10 cycles → `pe_ack` stays 0, `elem_cnt` stays 0.
- **Backpressure:** FIFO_DEPTH=2, `dot_ready`=0, run 3 vectors → `fifo_count`=2. On the third vector's last product, `pe_ack` is withheld. Raising `dot_ready` for one cycle → capture happens that cycle, `fifo_count` stays 2, results come out in order.
- **Wrap:** ACC_PRECISION=33, VECTOR_LEN=2, products 0xFFFFFFFF, 0xFFFFFFFF → `dot_out`=0x1_FFFFFFFE. Products 0xFFFFFFFF×3 with VECTOR_LEN=3 → value taken modulo 2^33.
- **Overrun:** two `mult_issued` pulses with no intervening `pe_ready` → `overrun`=1 and it stays 1 until `reset`.
- **Reset mid-vector:** after 2 of 4 products, assert `reset` for 1 cycle → all outputs 0. A following full vector 1,1,1,1 yields `dot_out`=4.
